// File: rtl/sigma_stream.sv
// Pipelined SHA-2 sigma unit: out0 = ROTR(in0,a) ^ ROTR(in0,b) ^ (SHR|ROTR)(in0,c)
// over a run of `len` words, with a run/done handshake and a two-stage datapath.
module sigma_stream #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned CNT_W   = 16,
  parameter int unsigned SHAMT_W = $clog2(DATA_W)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               run,
  output logic               done,
  input  logic [CNT_W-1:0]   len,
  input  logic               mode,
  input  logic [SHAMT_W-1:0] constant_0,
  input  logic [SHAMT_W-1:0] constant_1,
  input  logic [SHAMT_W-1:0] constant_2,
  input  logic [DATA_W-1:0]  in0,
  input  logic               in_valid,
  output logic [DATA_W-1:0]  out0,
  output logic               out_valid
);

  typedef enum logic [1:0] {IDLE, BUSY, DRAIN} state_t;

  state_t               state;
  state_t               state_nxt;

  logic [CNT_W-1:0]     cfg_len;
  logic                 cfg_mode;
  logic [SHAMT_W-1:0]   cfg_a;
  logic [SHAMT_W-1:0]   cfg_b;
  logic [SHAMT_W-1:0]   cfg_c;
  logic [CNT_W-1:0]     accepted;

  logic                 start_c;
  logic                 accept_c;
  logic                 last_c;

  logic                 s1_valid;
  logic [DATA_W-1:0]    s1_ra;
  logic [DATA_W-1:0]    s1_rb;
  logic [DATA_W-1:0]    s1_rc;
  logic [DATA_W-1:0]    ra_c;
  logic [DATA_W-1:0]    rb_c;
  logic [DATA_W-1:0]    rc_c;

  // Circular right rotate: shifting the doubled word keeps amount 0 an identity.
  function automatic logic [DATA_W-1:0] rotr(input logic [DATA_W-1:0] x,
                                             input logic [SHAMT_W-1:0] s);
    logic [2*DATA_W-1:0] w;
    w = {x, x} >> s;
    return w[DATA_W-1:0];
  endfunction

  // Next-state and handshake decode.
  always_comb begin
    state_nxt = state;
    start_c   = 1'b0;
    accept_c  = 1'b0;
    last_c    = 1'b0;
    case (state)
      IDLE: begin
        if (run && (len != '0)) begin
          start_c   = 1'b1;
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        accept_c = in_valid && (accepted < cfg_len);
        last_c   = accept_c && ((accepted + CNT_W'(1)) == cfg_len);
        if (last_c || (accepted == cfg_len)) state_nxt = DRAIN;
      end
      // Last word sits in S1; it reaches out0 on the same edge that returns to IDLE.
      DRAIN:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      done     <= 1'b1;
      cfg_len  <= '0;
      cfg_mode <= 1'b0;
      cfg_a    <= '0;
      cfg_b    <= '0;
      cfg_c    <= '0;
      accepted <= '0;
    end else begin
      state <= state_nxt;
      done  <= (state_nxt == IDLE);
      if (start_c) begin
        cfg_len  <= len;
        cfg_mode <= mode;
        cfg_a    <= constant_0;
        cfg_b    <= constant_1;
        cfg_c    <= constant_2;
        accepted <= '0;
      end else if (accept_c) begin
        accepted <= accepted + CNT_W'(1);
      end
    end
  end

  always_comb begin
    ra_c = rotr(in0, cfg_a);
    rb_c = rotr(in0, cfg_b);
    rc_c = cfg_mode ? rotr(in0, cfg_c) : (in0 >> cfg_c);
  end

  // Stage 1: the three shifted terms.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid <= 1'b0;
      s1_ra    <= '0;
      s1_rb    <= '0;
      s1_rc    <= '0;
    end else begin
      s1_valid <= accept_c;
      if (accept_c) begin
        s1_ra <= ra_c;
        s1_rb <= rb_c;
        s1_rc <= rc_c;
      end
    end
  end

  // Stage 2: XOR reduction; out0 holds between results.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0;
      out0      <= '0;
    end else begin
      out_valid <= s1_valid;
      if (s1_valid) out0 <= s1_ra ^ s1_rb ^ s1_rc;
    end
  end

endmodule

// File: tb/tb_sigma_stream.sv
// Bench for sigma_stream: 32- and 64-bit instances, scoreboard of expected
// results with due cycles, plus per-scenario handshake checks.
module tb_sigma_stream;
  localparam int unsigned CNT_W = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic             s_run, s_mode, s_iv, s_done, s_ov;
  logic [CNT_W-1:0] s_len;
  logic [4:0]       s_k0, s_k1, s_k2;
  logic [31:0]      s_in, s_out;

  logic             l_run, l_mode, l_iv, l_done, l_ov;
  logic [CNT_W-1:0] l_len;
  logic [5:0]       l_k0, l_k1, l_k2;
  logic [63:0]      l_in, l_out;

  sigma_stream #(.DATA_W(32), .CNT_W(CNT_W)) dut32 (
    .clk(clk), .rst(rst), .run(s_run), .done(s_done), .len(s_len), .mode(s_mode),
    .constant_0(s_k0), .constant_1(s_k1), .constant_2(s_k2),
    .in0(s_in), .in_valid(s_iv), .out0(s_out), .out_valid(s_ov));

  sigma_stream #(.DATA_W(64), .CNT_W(CNT_W)) dut64 (
    .clk(clk), .rst(rst), .run(l_run), .done(l_done), .len(l_len), .mode(l_mode),
    .constant_0(l_k0), .constant_1(l_k1), .constant_2(l_k2),
    .in0(l_in), .in_valid(l_iv), .out0(l_out), .out_valid(l_ov));

  typedef struct { int unsigned due; logic [63:0] data; } exp_t;
  exp_t q32[$];
  exp_t q64[$];
  exp_t e32, e64;

  int unsigned cyc = 0;
  int tests = 0;
  int fails = 0;
  int ov_cnt32 = 0;
  int ov_cnt64 = 0;

  bit c32_mode, c64_mode;
  int c32_a, c32_b, c32_c, c64_a, c64_b, c64_c;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [63:0] m_rot(input logic [63:0] x, input int s, input int w);
    logic [63:0] m;
    m = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    if (s == 0) return x & m;
    return ((x >> s) | (x << (w - s))) & m;
  endfunction

  function automatic logic [63:0] model(input logic [63:0] xi, input int w, input bit md,
                                        input int a, input int b, input int c);
    logic [63:0] x;
    x = (w == 64) ? xi : (xi & 64'h0000_0000_FFFF_FFFF);
    return m_rot(x, a, w) ^ m_rot(x, b, w) ^ (md ? m_rot(x, c, w) : (x >> c));
  endfunction

  // Scoreboards: each output pulse must match the oldest expectation and its due cycle.
  always @(negedge clk) begin
    if (s_ov === 1'b1) begin
      ov_cnt32++;
      tests++;
      if (q32.size() == 0) begin
        fails++;
        $display("FAIL sb32_unexpected got=%h at cyc %0d", s_out, cyc);
      end else begin
        e32 = q32.pop_front();
        if (s_out !== e32.data[31:0] || cyc != e32.due) begin
          fails++;
          $display("FAIL sb32_data got=%h@%0d exp=%h@%0d", s_out, cyc, e32.data[31:0], e32.due);
        end
      end
    end else if (q32.size() != 0 && q32[0].due <= cyc) begin
      tests++;
      fails++;
      $display("FAIL sb32_missing got=no_valid exp=%h@%0d", q32[0].data[31:0], q32[0].due);
      void'(q32.pop_front());
    end
  end

  always @(negedge clk) begin
    if (l_ov === 1'b1) begin
      ov_cnt64++;
      tests++;
      if (q64.size() == 0) begin
        fails++;
        $display("FAIL sb64_unexpected got=%h at cyc %0d", l_out, cyc);
      end else begin
        e64 = q64.pop_front();
        if (l_out !== e64.data || cyc != e64.due) begin
          fails++;
          $display("FAIL sb64_data got=%h@%0d exp=%h@%0d", l_out, cyc, e64.data, e64.due);
        end
      end
    end else if (q64.size() != 0 && q64[0].due <= cyc) begin
      tests++;
      fails++;
      $display("FAIL sb64_missing got=no_valid exp=%h@%0d", q64[0].data, q64[0].due);
      void'(q64.pop_front());
    end
  end

  task automatic start32(input int unsigned n, input bit md, input int a, input int b, input int c);
    @(negedge clk);
    s_run = 1'b1; s_len = CNT_W'(n); s_mode = md;
    s_k0 = 5'(a); s_k1 = 5'(b); s_k2 = 5'(c);
    c32_mode = md; c32_a = a % 32; c32_b = b % 32; c32_c = c % 32;
    @(negedge clk);
    s_run = 1'b0; s_len = CNT_W'($urandom); s_mode = 1'($urandom);
    s_k0 = 5'($urandom); s_k1 = 5'($urandom); s_k2 = 5'($urandom);
  endtask

  task automatic start64(input int unsigned n, input bit md, input int a, input int b, input int c);
    @(negedge clk);
    l_run = 1'b1; l_len = CNT_W'(n); l_mode = md;
    l_k0 = 6'(a); l_k1 = 6'(b); l_k2 = 6'(c);
    c64_mode = md; c64_a = a % 64; c64_b = b % 64; c64_c = c % 64;
    @(negedge clk);
    l_run = 1'b0; l_len = CNT_W'($urandom); l_mode = 1'($urandom);
    l_k0 = 6'($urandom); l_k1 = 6'($urandom); l_k2 = 6'($urandom);
  endtask

  task automatic drive32(input bit v, input logic [31:0] d, input bit acc);
    @(negedge clk);
    s_iv = v; s_in = d;
    if (acc) q32.push_back('{cyc + 2, model(64'(d), 32, c32_mode, c32_a, c32_b, c32_c)});
  endtask

  task automatic drive64(input bit v, input logic [63:0] d, input bit acc);
    @(negedge clk);
    l_iv = v; l_in = d;
    if (acc) q64.push_back('{cyc + 2, model(d, 64, c64_mode, c64_a, c64_b, c64_c)});
  endtask

  task automatic test_reset();
    #1 rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    tests++;
    if (s_done !== 1'b1 || s_ov !== 1'b0 || s_out !== 32'h0) begin
      fails++;
      $display("FAIL reset32 got done=%b ov=%b out=%h exp done=1 ov=0 out=0", s_done, s_ov, s_out);
    end
    tests++;
    if (l_done !== 1'b1 || l_ov !== 1'b0 || l_out !== 64'h0) begin
      fails++;
      $display("FAIL reset64 got done=%b ov=%b out=%h exp done=1 ov=0 out=0", l_done, l_ov, l_out);
    end
    rst = 1'b1;
  endtask

  task automatic test_small_sigma32();
    start32(1, 1'b0, 7, 18, 3);
    drive32(1'b1, 32'h0000_0001, 1'b1);
    drive32(1'b0, 32'h0, 1'b0);
    tests++;
    if (s_done !== 1'b0 || s_ov !== 1'b0) begin
      fails++;
      $display("FAIL t1_drain got done=%b ov=%b exp done=0 ov=0", s_done, s_ov);
    end
    drive32(1'b0, 32'h0, 1'b0);
    tests++;
    if (s_ov !== 1'b1 || s_done !== 1'b1 || s_out !== 32'h0200_4000) begin
      fails++;
      $display("FAIL t1_result got ov=%b done=%b out=%h exp ov=1 done=1 out=02004000", s_ov, s_done, s_out);
    end
    drive32(1'b0, 32'h0, 1'b0);
    tests++;
    if (s_ov !== 1'b0 || s_out !== 32'h0200_4000) begin
      fails++;
      $display("FAIL t1_hold got ov=%b out=%h exp ov=0 out=02004000", s_ov, s_out);
    end
  endtask

  task automatic test_big_sigma32();
    start32(1, 1'b1, 6, 11, 25);
    drive32(1'b1, 32'h0000_0001, 1'b1);
    drive32(1'b0, 32'h0, 1'b0);
    drive32(1'b0, 32'h0, 1'b0);
    tests++;
    if (s_ov !== 1'b1 || s_done !== 1'b1 || s_out !== 32'h0420_0080) begin
      fails++;
      $display("FAIL t2_result got ov=%b done=%b out=%h exp ov=1 done=1 out=04200080", s_ov, s_done, s_out);
    end
  endtask

  task automatic test_sigma64();
    start64(1, 1'b0, 1, 8, 7);
    drive64(1'b1, 64'h1, 1'b1);
    drive64(1'b0, 64'h0, 1'b0);
    drive64(1'b0, 64'h0, 1'b0);
    tests++;
    if (l_ov !== 1'b1 || l_done !== 1'b1 || l_out !== 64'h8100_0000_0000_0000) begin
      fails++;
      $display("FAIL t3_result got ov=%b done=%b out=%h exp ov=1 done=1 out=8100000000000000", l_ov, l_done, l_out);
    end
    start64(3, 1'b1, 28, 34, 39);
    for (int i = 0; i < 3; i++) drive64(1'b1, {$urandom, $urandom}, 1'b1);
    for (int i = 0; i < 4; i++) drive64(1'b0, 64'h0, 1'b0);
    tests++;
    if (l_done !== 1'b1 || q64.size() != 0) begin
      fails++;
      $display("FAIL t3_b2b got done=%b pending=%0d exp done=1 pending=0", l_done, q64.size());
    end
  endtask

  task automatic test_back_to_back();
    ov_cnt32 = 0;
    start32(4, 1'b1, 13, 0, 31);
    for (int i = 0; i < 6; i++) drive32(1'b1, $urandom, i < 4);
    for (int i = 0; i < 4; i++) drive32(1'b0, 32'h0, 1'b0);
    tests++;
    if (ov_cnt32 != 4 || s_done !== 1'b1 || q32.size() != 0) begin
      fails++;
      $display("FAIL t4_count got pulses=%0d done=%b pending=%0d exp pulses=4 done=1 pending=0",
               ov_cnt32, s_done, q32.size());
    end
  endtask

  task automatic test_gaps();
    ov_cnt32 = 0;
    start32(2, 1'b0, 17, 19, 10);
    drive32(1'b1, $urandom, 1'b1);
    @(negedge clk);
    s_iv = 1'b0; s_run = 1'b1; s_len = CNT_W'(1); s_mode = 1'b1; s_k0 = 5'd1;
    @(negedge clk);
    s_run = 1'b0;
    drive32(1'b1, $urandom, 1'b1);
    @(negedge clk);
    s_iv = 1'b0; s_run = 1'b1; s_len = CNT_W'(5);
    tests++;
    if (s_done !== 1'b0) begin
      fails++;
      $display("FAIL t5_drain got done=%b exp done=0", s_done);
    end
    @(negedge clk);
    s_run = 1'b0;
    tests++;
    if (s_done !== 1'b1 || s_ov !== 1'b1) begin
      fails++;
      $display("FAIL t5_last got done=%b ov=%b exp done=1 ov=1", s_done, s_ov);
    end
    for (int i = 0; i < 3; i++) begin
      drive32(1'b1, $urandom, 1'b0);
      tests++;
      if (s_done !== 1'b1) begin
        fails++;
        $display("FAIL t5_idle_run got done=%b exp done=1", s_done);
      end
    end
    drive32(1'b0, 32'h0, 1'b0);
    drive32(1'b0, 32'h0, 1'b0);
    tests++;
    if (ov_cnt32 != 2) begin
      fails++;
      $display("FAIL t5_count got pulses=%0d exp pulses=2", ov_cnt32);
    end
  endtask

  task automatic test_len_zero();
    ov_cnt32 = 0;
    start32(0, 1'b0, 7, 18, 3);
    for (int i = 0; i < 3; i++) begin
      drive32(1'b1, $urandom, 1'b0);
      tests++;
      if (s_done !== 1'b1) begin
        fails++;
        $display("FAIL t6_len0_done got done=%b exp done=1", s_done);
      end
    end
    drive32(1'b0, 32'h0, 1'b0);
    drive32(1'b0, 32'h0, 1'b0);
    tests++;
    if (ov_cnt32 != 0) begin
      fails++;
      $display("FAIL t6_len0_pulses got pulses=%0d exp pulses=0", ov_cnt32);
    end
  endtask

  task automatic test_reset_mid_run();
    start32(3, 1'b0, 7, 18, 3);
    drive32(1'b1, $urandom, 1'b1);
    drive32(1'b1, $urandom, 1'b1);
    @(negedge clk);
    s_iv = 1'b0;
    #2 rst = 1'b0;
    q32.delete();
    #1;
    tests++;
    if (s_done !== 1'b1 || s_ov !== 1'b0 || s_out !== 32'h0) begin
      fails++;
      $display("FAIL t6_abort got done=%b ov=%b out=%h exp done=1 ov=0 out=0", s_done, s_ov, s_out);
    end
    @(negedge clk);
    rst = 1'b1;
    ov_cnt32 = 0;
    drive32(1'b0, 32'h0, 1'b0);
    drive32(1'b0, 32'h0, 1'b0);
    tests++;
    if (ov_cnt32 != 0 || s_done !== 1'b1) begin
      fails++;
      $display("FAIL t6_no_partial got pulses=%0d done=%b exp pulses=0 done=1", ov_cnt32, s_done);
    end
    test_small_sigma32();
  endtask

  initial begin
    s_run = 1'b0; s_len = '0; s_mode = 1'b0; s_k0 = '0; s_k1 = '0; s_k2 = '0;
    s_in = '0; s_iv = 1'b0;
    l_run = 1'b0; l_len = '0; l_mode = 1'b0; l_k0 = '0; l_k1 = '0; l_k2 = '0;
    l_in = '0; l_iv = 1'b0;
    test_reset();
    test_small_sigma32();
    test_big_sigma32();
    test_sigma64();
    test_back_to_back();
    test_gaps();
    test_len_zero();
    test_reset_mid_run();
    repeat (4) @(negedge clk);
    tests++;
    if (q32.size() + q64.size() != 0) begin
      fails++;
      $display("FAIL leftover got pending=%0d exp pending=0", q32.size() + q64.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
